// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-ported, fixed-latency memory between the fetch port and the
// load/store port; alternates priority on ties and returns registered read data.
module unified_mem_arbiter #(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_f3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [2:0]        mem_f3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int               CNT_W    = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);
  localparam logic [2:0]       F3_WORD  = 3'b010;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;       // 1 = data port owns the access
  logic              last_gnt_q, last_gnt_d; // 1 = data port was granted last
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              grant_d;
  logic              in_access, in_done;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_gnt_d = last_gnt_q;
    cnt_d      = cnt_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    grant_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // On a tie the port that was not served last wins.
        grant_d = d_req & (~if_req | ~last_gnt_q);
        if (if_req | d_req) begin
          owner_d    = grant_d;
          last_gnt_d = grant_d;
          cnt_d      = '0;
          state_d    = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          if (!owner_q) begin
            if_rdata_d = mem_rdata;
          end else if (!d_we) begin
            d_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      last_gnt_q <= 1'b0;
      cnt_q      <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign in_access = (state_q == S_ACCESS);
  assign in_done   = (state_q == S_DONE);

  // Memory controls are decoded from registered state; address/data come from the owner.
  assign mem_en    = in_access;
  assign mem_we    = in_access & owner_q & d_we;
  assign mem_f3    = !in_access ? 3'b000 : (owner_q ? d_f3 : F3_WORD);
  assign mem_addr  = !in_access ? '0 : (owner_q ? d_addr : if_addr);
  assign mem_wdata = (in_access & owner_q) ? d_wdata : '0;

  assign if_done  = in_done & ~owner_q;
  assign d_done   = in_done & owner_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign busy     = (state_q != S_IDLE);

endmodule
